adpll_tx_ser: RTL and testbench
===============================

ADPLL_TX_SER -- requirements
Module: adpll_tx_ser

Interface
REQ-001 SHALL have parameter DATA_W, default 32, CPU data width.
REQ-002 SHALL have parameter ADDR_W, default 2, CPU address width.
REQ-003 SHALL have parameter DEPTH, default 8, byte FIFO depth (power of 2).
REQ-004 SHALL have parameter DIV_W, default 16, bit-period divider width.
REQ-005 SHALL have port clk, input, 1 bit, single clock; one clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port valid, input, 1 bit, CPU request.
REQ-008 SHALL have port address, input, ADDR_W bits, register select.
REQ-009 SHALL have port wdata, input, DATA_W bits, write data.
REQ-010 SHALL have port wstrb, input, 1 bit, 1 = write, 0 = read.
REQ-011 SHALL have port rdata, output, DATA_W bits, read data.
REQ-012 SHALL have port ready, output, 1 bit, CPU acknowledge.
REQ-013 SHALL have port data_mod, output, 1 bit, serial modulation bit to the ADPLL controller.
REQ-014 SHALL have port bit_stb, output, 1 bit, one-cycle pulse on each new data_mod bit.
REQ-015 SHALL have port tx_busy, output, 1 bit, high while in LOAD or SHIFT.

Function
REQ-016 SHALL register map: 0 TX_DATA (W: push wdata[7:0]); 1 BIT_DIV (R/W, DIV_W bits); 2 CTRL (R/W: bit0 en, bit1 lsb_first, bit2 flush, self-clearing); 3 STATUS (R).
REQ-017 SHALL return STATUS = {ovf[8], busy[7], full[6], empty[5], level[4:0]}, zero-extended to DATA_W.
REQ-018 SHALL clear ovf when STATUS is written with wdata[8]=1.
REQ-019 SHALL drive ready one cycle after valid (registered copy of valid); rdata SHALL be combinational from address.
REQ-020 SHALL, on a TX_DATA push with the FIFO full, drop the byte, leave level unchanged, and set ovf.
REQ-021 SHALL, on a simultaneous push and pop, leave level unchanged with data ordering preserved.
REQ-022 SHALL implement FSM IDLE -> LOAD -> SHIFT.
- IDLE -> LOAD when en=1 and FIFO non-empty.
- LOAD: pop one byte into an 8-bit shift register; reset bit counter and timer; go to SHIFT.
- SHIFT -> IDLE after bit 7 when en=0 or FIFO empty.
- SHIFT -> SHIFT (pop next byte in the same cycle, no gap) after bit 7 when en=1 and FIFO non-empty.
REQ-023 SHALL hold each bit for BIT_DIV+1 clk cycles; BIT_DIV=0 SHALL give one clock per bit.
REQ-024 SHALL send MSB first when lsb_first=0, LSB first when lsb_first=1; lsb_first SHALL be sampled at LOAD.
REQ-025 SHALL update data_mod and pulse bit_stb on the same clock edge; data_mod SHALL be 0 in IDLE.
REQ-026 SHALL sample a BIT_DIV write mid-bit at the next bit boundary, never truncating the current bit.
REQ-027 SHALL, on en=0 mid-byte, complete the current byte and then go to IDLE.
REQ-028 SHALL, on flush=1, empty the FIFO, abort the shift, force data_mod=0, and enter IDLE on the next cycle; flush SHALL take priority over a simultaneous push.
REQ-029 SHALL make the first bit appear on data_mod 2 cycles after en rises with a non-empty FIFO (IDLE -> LOAD -> SHIFT).

Reset
REQ-030 SHALL, while rst_n=0, force: FSM IDLE; FIFO empty, level 0; ovf 0; BIT_DIV 0; en 0; lsb_first 0; data_mod 0; bit_stb 0; tx_busy 0; ready 0.
REQ-031 SHALL, on reset assertion mid-operation, abort immediately and discard FIFO contents.

Verification
REQ-032 SHALL cover: BIT_DIV=3, push 0xA5, en=1 -> data_mod 1,0,1,0,0,1,0,1, each bit 4 cycles, 8 bit_stb pulses, then IDLE.
REQ-033 SHALL cover: lsb_first=1, push 0x01 -> first bit 1, then seven 0s.
REQ-034 SHALL cover: 9 pushes with en=0 -> level=8, full=1, ovf=1; a STATUS write with bit8=1 -> ovf=0.
REQ-035 SHALL cover: push 0xFF and 0x00 back-to-back, BIT_DIV=0 -> 16 consecutive bits with no gap, tx_busy high throughout.
REQ-036 SHALL cover: flush asserted mid-byte with 3 bytes queued -> next cycle data_mod=0, level=0, tx_busy=0.
REQ-037 SHALL cover: rst_n pulsed low mid-shift -> all outputs at reset values asynchronously; STATUS reads 0x20.

Source files
------------

// File: rtl/adpll_tx_ser.sv
// adpll_tx_ser: CPU-programmable byte FIFO feeding a bit serialiser that
// drives the ADPLL modulation input, one bit per BIT_DIV+1 clocks.
module adpll_tx_ser #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              data_mod,
  output logic              bit_stb,
  output logic              tx_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, level;
  logic              full, empty;
  logic [DIV_W-1:0]  bit_div, div_cur, timer;
  logic              en, lsb_first, lsb_cur, ovf;
  logic [7:0]        shreg, head;
  logic [2:0]        bit_cnt;
  logic              wr, sel_tx, sel_div, sel_ctrl, sel_stat;
  logic              flush, push_req, push, pop, at_bound, last_bit;
  logic [8:0]        status;
  logic              unused_wdata;

  assign wr       = valid & wstrb;
  assign sel_tx   = (address == ADDR_W'(0));
  assign sel_div  = (address == ADDR_W'(1));
  assign sel_ctrl = (address == ADDR_W'(2));
  assign sel_stat = (address == ADDR_W'(3));
  assign flush    = wr & sel_ctrl & wdata[2];
  assign push_req = wr & sel_tx & ~flush;
  assign push     = push_req & ~full;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign at_bound = (timer == div_cur);
  assign last_bit = (bit_cnt == 3'd7);
  // A byte is popped on the LOAD cycle, or straight from the last bit
  // boundary of the previous byte so back-to-back bytes have no gap.
  assign pop = ~flush & ((state == S_LOAD) |
               ((state == S_SHIFT) & at_bound & last_bit & en & ~empty));

  assign status       = {ovf, tx_busy, full, empty, 5'(level)};
  assign unused_wdata = ^wdata;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata[7:0];
  end

  // FIFO pointers; flush empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // CPU-visible registers and acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready     <= 1'b0;
      bit_div   <= '0;
      en        <= 1'b0;
      lsb_first <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ready <= valid;
      if (wr & sel_div) bit_div <= wdata[DIV_W-1:0];
      if (wr & sel_ctrl) begin
        en        <= wdata[0];
        lsb_first <= wdata[1];
      end
      if (push_req & full)                ovf <= 1'b1;
      else if (wr & sel_stat & wdata[8])  ovf <= 1'b0;
    end
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    if (sel_div)       rdata = DATA_W'(bit_div);
    else if (sel_ctrl) rdata = DATA_W'({lsb_first, en});
    else if (sel_stat) rdata = DATA_W'(status);
  end

  // Serialiser FSM with registered data_mod/bit_stb/tx_busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      lsb_cur  <= 1'b0;
      bit_cnt  <= '0;
      timer    <= '0;
      div_cur  <= '0;
      data_mod <= 1'b0;
      bit_stb  <= 1'b0;
      tx_busy  <= 1'b0;
    end else begin
      bit_stb <= 1'b0;
      if (flush) begin
        state    <= S_IDLE;
        data_mod <= 1'b0;
        tx_busy  <= 1'b0;
      end else if (pop) begin
        state    <= S_SHIFT;
        shreg    <= head;
        lsb_cur  <= lsb_first;
        data_mod <= lsb_first ? head[0] : head[7];
        bit_stb  <= 1'b1;
        bit_cnt  <= '0;
        timer    <= '0;
        div_cur  <= bit_div;
        tx_busy  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            data_mod <= 1'b0;
            if (en & ~empty) begin
              state   <= S_LOAD;
              tx_busy <= 1'b1;
            end
          end
          S_SHIFT: begin
            if (!at_bound) begin
              timer <= timer + 1'b1;
            end else if (last_bit) begin
              state    <= S_IDLE;
              data_mod <= 1'b0;
              tx_busy  <= 1'b0;
            end else begin
              // BIT_DIV is resampled only here, so a mid-bit write
              // never shortens the bit already on the line.
              bit_cnt  <= bit_cnt + 1'b1;
              timer    <= '0;
              div_cur  <= bit_div;
              bit_stb  <= 1'b1;
              data_mod <= lsb_cur ? shreg[1] : shreg[6];
              shreg    <= lsb_cur ? (shreg >> 1) : (shreg << 1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adpll_tx_ser.sv
// tb_adpll_tx_ser: scoreboard bench; expected bits are queued as bytes are
// pushed and compared as bit_stb pulses appear.
module tb_adpll_tx_ser;

  logic        clk = 1'b0;
  logic        rst_n, valid, wstrb;
  logic [1:0]  address;
  logic [31:0] wdata, rdata;
  logic        ready, data_mod, bit_stb, tx_busy;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];
  int exp_period = 1;
  bit run_active = 0;
  int gap_cnt    = 0;
  int stb_count  = 0;
  bit tb_lsb     = 0;

  adpll_tx_ser #(.DATA_W(32), .ADDR_W(2), .DEPTH(8), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .data_mod(data_mod), .bit_stb(bit_stb), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / bit timing monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      run_active = 0;
    end else begin
      if (bit_stb) begin
        stb_count++;
        check("stb_busy", tx_busy, 1);
        if (exp_q.size() == 0) check("sb_extra_stb", bit_stb, 0);
        else                   check("sb_bit", data_mod, exp_q.pop_front());
        if (run_active) check("bit_period", gap_cnt, exp_period);
        run_active = 1;
        gap_cnt    = 1;
      end else if (tx_busy) begin
        gap_cnt++;
      end
      if (!tx_busy) begin
        run_active = 0;
        check("idle_mod", data_mod, 0);
      end
    end
  end

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    valid = 1; wstrb = 1; address = a; wdata = d;
    @(negedge clk);
    check("wr_ready", ready, 1);
    valid = 0; wstrb = 0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    valid = 1; wstrb = 0; address = a;
    #1 d = rdata;
    check(tag, d, exp);
    @(negedge clk);
    check("rd_ready", ready, 1);
    valid = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit queue_it);
    cpu_write(2'd0, {24'h0, b});
    if (queue_it)
      for (int i = 0; i < 8; i++) exp_q.push_back(tb_lsb ? b[i] : b[7-i]);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((tx_busy || exp_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n < max_cyc), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst_n = 0; valid = 0; wstrb = 0; address = 0; wdata = 0;
    #1;
    check("rst_data_mod", data_mod, 0);
    check("rst_bit_stb", bit_stb, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_ready", ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    read_check("rst_status", 2'd3, 32'h20);
    read_check("rst_bitdiv", 2'd1, 32'h0);
    read_check("rst_ctrl", 2'd2, 32'h0);

    // 0xA5, MSB first, 4 clocks per bit, two-cycle start latency
    cpu_write(2'd1, 32'd3);
    read_check("bitdiv_rb", 2'd1, 32'd3);
    exp_period = 4; tb_lsb = 0;
    push_byte(8'hA5, 1);
    s0 = stb_count;
    cpu_write(2'd2, 32'h1);
    @(negedge clk);
    check("lat_load_stb", bit_stb, 0);
    check("lat_load_busy", tx_busy, 1);
    check("lat_load_mod", data_mod, 0);
    @(negedge clk);
    check("lat_first_stb", bit_stb, 1);
    check("lat_first_bit", data_mod, 1);
    wait_idle(200);
    check("a5_stb_cnt", stb_count - s0, 8);
    read_check("a5_status", 2'd3, 32'h20);

    // 0x01, LSB first, 2 clocks per bit
    cpu_write(2'd2, 32'h0);
    cpu_write(2'd1, 32'd1);
    exp_period = 2; tb_lsb = 1;
    cpu_write(2'd2, 32'h2);
    push_byte(8'h01, 1);
    s0 = stb_count;
    cpu_write(2'd2, 32'h3);
    wait_idle(200);
    check("lsb_stb_cnt", stb_count - s0, 8);

    // en dropped mid-byte: current byte completes, second stays queued
    cpu_write(2'd2, 32'h0);
    tb_lsb = 0;
    push_byte(8'h3C, 1);
    push_byte(8'h81, 0);
    s0 = stb_count;
    cpu_write(2'd2, 32'h1);
    repeat (6) @(negedge clk);
    cpu_write(2'd2, 32'h0);
    wait_idle(200);
    check("endrop_stb_cnt", stb_count - s0, 8);
    read_check("endrop_status", 2'd3, 32'h01);
    cpu_write(2'd2, 32'h4);
    read_check("flush1_status", 2'd3, 32'h20);

    // overflow: nine pushes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) push_byte(8'(i), 0);
    read_check("ovf_status", 2'd3, 32'h148);
    cpu_write(2'd3, 32'h100);
    read_check("ovf_clr_status", 2'd3, 32'h48);
    cpu_write(2'd2, 32'h4);
    read_check("flush2_status", 2'd3, 32'h20);
    read_check("ctrl_selfclr", 2'd2, 32'h0);

    // back-to-back bytes, one clock per bit, no gap
    cpu_write(2'd1, 32'd0);
    exp_period = 1;
    push_byte(8'hFF, 1);
    push_byte(8'h00, 1);
    s0 = stb_count;
    cpu_write(2'd2, 32'h1);
    wait_idle(200);
    check("b2b_stb_cnt", stb_count - s0, 16);

    // flush mid-byte with three bytes queued
    cpu_write(2'd2, 32'h0);
    cpu_write(2'd1, 32'd3);
    exp_period = 4;
    push_byte(8'hC3, 1);
    push_byte(8'h11, 0);
    push_byte(8'h22, 0);
    cpu_write(2'd2, 32'h1);
    repeat (10) @(negedge clk);
    check("pre_flush_busy", tx_busy, 1);
    cpu_write(2'd2, 32'h4);
    exp_q.delete();
    check("flush_mod", data_mod, 0);
    check("flush_busy", tx_busy, 0);
    read_check("flush3_status", 2'd3, 32'h20);

    // asynchronous reset mid-shift
    push_byte(8'hFF, 1);
    push_byte(8'hFF, 1);
    cpu_write(2'd2, 32'h1);
    repeat (8) @(negedge clk);
    check("pre_rst_busy", tx_busy, 1);
    check("pre_rst_mod", data_mod, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_mod", data_mod, 0);
    check("arst_stb", bit_stb, 0);
    check("arst_busy", tx_busy, 0);
    check("arst_ready", ready, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    read_check("arst_status", 2'd3, 32'h20);
    read_check("arst_bitdiv", 2'd1, 32'h0);
    read_check("arst_ctrl", 2'd2, 32'h0);

    repeat (4) @(negedge clk);
    check("sb_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
